// File: rtl/mem_pkg.sv
// Shared types and constants for the global memory controller.
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } e_mem_state;

  localparam int unsigned DefaultLatency = 5;

  // Byte address to word index; the two LSBs select a byte and are ignored.
  function automatic logic [29:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/global_mem_array.sv
// Word store: one combinational read port, two synchronous write ports (core wins on a clash).
module global_mem_array #(
  parameter int unsigned Depth = 4096,
  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic          clk_i,
  input  logic [Aw-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o,
  input  logic          core_we_i,
  input  logic [Aw-1:0] core_idx_i,
  input  logic [31:0]   core_data_i,
  input  logic          oob_we_i,
  input  logic [Aw-1:0] oob_idx_i,
  input  logic [31:0]   oob_data_i
);

  logic [31:0] mem_q [Depth];

  // The later non-blocking write takes effect, giving the core port priority.
  always_ff @(posedge clk_i) begin
    if (oob_we_i)  mem_q[oob_idx_i]  <= oob_data_i;
    if (core_we_i) mem_q[core_idx_i] <= core_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/global_mem_ctrl.sv
// Single-outstanding-request memory controller with fixed completion latency
// and a side-band loader port.
module global_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE_WORDS = 4096,
  parameter int unsigned LATENCY        = DefaultLatency
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_ack,
  output logic        mem_busy,
  input  logic        oob_wr_en,
  input  logic [31:0] oob_wr_addr,
  input  logic [31:0] oob_wr_data
);

  localparam int unsigned Aw = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
  localparam logic [7:0] CntInit = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  e_mem_state  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        ack_q, ack_d;

  logic        req;
  logic [29:0] req_idx, oob_idx;
  logic        cmp_en, cmp_wr, cmp_in_range, oob_in_range;
  logic [29:0] cmp_idx;
  logic [31:0] cmp_data, arr_rd_data;
  logic        unused_addr_lsbs;

  assign req              = mem_rd_req | mem_wr_req;
  assign req_idx          = word_idx(mem_addr);
  assign oob_idx          = word_idx(oob_wr_addr);
  assign cmp_in_range     = 32'(cmp_idx) < MEM_SIZE_WORDS;
  assign oob_in_range     = 32'(oob_idx) < MEM_SIZE_WORDS;
  assign unused_addr_lsbs = ^{mem_addr[1:0], oob_wr_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    wr_d      = wr_q;
    rd_data_d = rd_data_q;
    ack_d     = 1'b0;
    cmp_en    = 1'b0;
    cmp_wr    = wr_q;
    cmp_idx   = idx_q;
    cmp_data  = data_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d  = req_idx;
          data_d = mem_wr_data;
          wr_d   = mem_wr_req;
          if (LATENCY == 1) begin
            // Single-cycle latency completes straight from the request inputs.
            cmp_en   = 1'b1;
            cmp_wr   = mem_wr_req;
            cmp_idx  = req_idx;
            cmp_data = mem_wr_data;
          end else begin
            cnt_d   = CntInit;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          cmp_en  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cmp_en) begin
      ack_d = 1'b1;
      if (!cmp_wr) rd_data_d = cmp_in_range ? arr_rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
    end
  end

  global_mem_array #(
    .Depth(MEM_SIZE_WORDS)
  ) u_array (
    .clk_i      (clk),
    .rd_idx_i   (cmp_idx[Aw-1:0]),
    .rd_data_o  (arr_rd_data),
    .core_we_i  (cmp_en & cmp_wr & cmp_in_range),
    .core_idx_i (cmp_idx[Aw-1:0]),
    .core_data_i(cmp_data),
    .oob_we_i   (oob_wr_en & oob_in_range),
    .oob_idx_i  (oob_idx[Aw-1:0]),
    .oob_data_i (oob_wr_data)
  );

  assign mem_rd_data = rd_data_q;
  assign mem_ack     = ack_q;
  assign mem_busy    = (state_q == WAIT);

endmodule

// File: tb/tb_global_mem_ctrl.sv
// Bench: two controllers (latency 5 / 4096 words, latency 1 / 16 words) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_global_mem_ctrl;

  localparam int unsigned SizeA = 4096;
  localparam int unsigned LatA  = 5;
  localparam int unsigned SizeB = 16;
  localparam int unsigned LatB  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0, mem_wr_data = '0, oob_wr_addr = '0, oob_wr_data = '0;
  logic        mem_rd_req = 1'b0, mem_wr_req = 1'b0, oob_wr_en = 1'b0;
  logic [31:0] rd_a, rd_b;
  logic        ack_a, ack_b, busy_a, busy_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  global_mem_ctrl #(.MEM_SIZE_WORDS(SizeA), .LATENCY(LatA)) u_dut_a (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data), .mem_rd_data(rd_a),
    .mem_ack(ack_a), .mem_busy(busy_a), .oob_wr_en(oob_wr_en),
    .oob_wr_addr(oob_wr_addr), .oob_wr_data(oob_wr_data)
  );

  global_mem_ctrl #(.MEM_SIZE_WORDS(SizeB), .LATENCY(LatB)) u_dut_b (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data), .mem_rd_data(rd_b),
    .mem_ack(ack_b), .mem_busy(busy_b), .oob_wr_en(oob_wr_en),
    .oob_wr_addr(oob_wr_addr), .oob_wr_data(oob_wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each request has an absolute completion edge number.
  longint unsigned cyc = 0;
  bit              m_pend [2];
  longint unsigned m_done [2];
  bit              m_wr   [2];
  logic [31:0]     m_addr [2];
  logic [31:0]     m_data [2];
  bit              m_ack  [2];
  bit              m_busy [2];
  logic [31:0]     m_rd   [2];
  logic [31:0]     m_mem  [2][SizeA];

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? LatA : LatB;
  endfunction

  function automatic bit in_range(input int k, input logic [31:0] addr);
    return (addr >> 2) < ((k == 0) ? SizeA : SizeB);
  endfunction

  task automatic model_step(input int k);
    bit          c_en, c_wr;
    logic [31:0] c_addr, c_data;
    c_en = 0; c_wr = 0; c_addr = '0; c_data = '0;
    m_ack[k] = 0;
    if (m_pend[k] && cyc == m_done[k]) begin
      c_en = 1; c_wr = m_wr[k]; c_addr = m_addr[k]; c_data = m_data[k];
      m_pend[k] = 0;
    end else if (!m_pend[k] && (mem_rd_req || mem_wr_req)) begin
      if (lat_of(k) == 1) begin
        c_en = 1; c_wr = mem_wr_req; c_addr = mem_addr; c_data = mem_wr_data;
      end else begin
        m_pend[k] = 1;
        m_done[k] = cyc + lat_of(k) - 1;
        m_wr[k]   = mem_wr_req;
        m_addr[k] = mem_addr;
        m_data[k] = mem_wr_data;
      end
    end
    if (c_en) begin
      m_ack[k] = 1;
      if (!c_wr) m_rd[k] = in_range(k, c_addr) ? m_mem[k][c_addr >> 2] : 32'h0;
    end
    if (oob_wr_en && in_range(k, oob_wr_addr)) m_mem[k][oob_wr_addr >> 2] = oob_wr_data;
    if (c_en && c_wr && in_range(k, c_addr)) m_mem[k][c_addr >> 2] = c_data;
    m_busy[k] = m_pend[k];
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 0; m_ack[k] = 0; m_busy[k] = 0; m_rd[k] = '0;
      end
    end else begin
      model_step(0);
      model_step(1);
      cyc++;
    end
  end

  always @(negedge clk) begin
    check("a_ack", 32'(ack_a), 32'(m_ack[0]));
    check("a_busy", 32'(busy_a), 32'(m_busy[0]));
    check("a_rd_data", rd_a, m_rd[0]);
    check("b_ack", 32'(ack_b), 32'(m_ack[1]));
    check("b_busy", 32'(busy_b), 32'(m_busy[1]));
    check("b_rd_data", rd_b, m_rd[1]);
  end

  task automatic oob(input logic [31:0] addr, input logic [31:0] data);
    oob_wr_en = 1'b1; oob_wr_addr = addr; oob_wr_data = data;
    @(negedge clk);
    oob_wr_en = 1'b0;
  endtask

  // One request in cycle 0, optional side-band write in cycle oob_at, n cycles observed.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input int n, input int oob_at,
                     input logic [31:0] oaddr, input logic [31:0] odata,
                     output int fa, output int fb, output int na, output int nb,
                     output int ba, output int bb, output logic [31:0] da,
                     output logic [31:0] db);
    fa = 0; fb = 0; na = 0; nb = 0; ba = 0; bb = 0; da = '0; db = '0;
    mem_addr = addr; mem_wr_data = data; oob_wr_addr = oaddr; oob_wr_data = odata;
    for (int i = 0; i < n; i++) begin
      mem_rd_req = rd & (i == 0);
      mem_wr_req = wr & (i == 0);
      oob_wr_en  = (i == oob_at);
      @(negedge clk);
      if (ack_a) begin na++; if (fa == 0) begin fa = i + 1; da = rd_a; end end
      if (ack_b) begin nb++; if (fb == 0) begin fb = i + 1; db = rd_b; end end
      if (busy_a) ba++;
      if (busy_b) bb++;
    end
    mem_rd_req = 1'b0; mem_wr_req = 1'b0; oob_wr_en = 1'b0;
  endtask

  initial begin
    int          fa, fb, na, nb, ba, bb, acks, last_ack;
    logic [31:0] da, db, first_d;

    // Requests while held in reset are ignored.
    repeat (2) @(negedge clk);
    mem_rd_req = 1'b1; mem_addr = 32'h40;
    @(negedge clk);
    mem_rd_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_hold_ack_a", 32'(ack_a), 0);
      check("rst_hold_busy_a", 32'(busy_a), 0);
      check("rst_hold_rd_a", rd_a, 0);
      check("rst_hold_ack_b", 32'(ack_b), 0);
    end
    #2 rst = 1'b1;
    @(negedge clk);

    for (int w = 0; w < int'(SizeA); w++) oob(32'(w * 4), $urandom);
    oob(32'h0, 32'd1);
    oob(32'h4, 32'd2);
    oob(32'h8, 32'd3);

    // Write then read 0x40 (out of range for the 16-word instance).
    txn(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("wr_ack_cycle_a", fa, 5);
    check("wr_busy_cycles_a", ba, 4);
    check("wr_ack_count_a", na, 1);
    check("wr_ack_cycle_b", fb, 1);
    check("wr_busy_cycles_b", bb, 0);
    txn(1'b1, 1'b0, 32'h40, '0, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("rd_ack_cycle_a", fa, 5);
    check("rd_busy_cycles_a", ba, 4);
    check("rd_data_a", da, 32'hDEADBEEF);
    check("rd_oor_data_b", db, 32'h0);

    // Back-to-back reads at latency 1.
    for (int i = 0; i < 3; i++) begin
      mem_rd_req = 1'b1; mem_addr = 32'(i * 4);
      @(negedge clk);
      check("b2b_ack_b", 32'(ack_b), 1);
      check("b2b_data_b", rd_b, 32'(i + 1));
      check("b2b_busy_b", 32'(busy_b), 0);
    end
    mem_rd_req = 1'b0;
    repeat (6) @(negedge clk);

    // Read while busy is dropped; read in the ack cycle is accepted.
    acks = 0; last_ack = 0; first_d = '0;
    for (int i = 0; i < 12; i++) begin
      mem_rd_req = (i == 0) || (i == 2) || (i == 5);
      mem_addr   = (i == 0) ? 32'h4 : (i == 2) ? 32'h8 : 32'hC;
      @(negedge clk);
      if (ack_a) begin
        acks++;
        last_ack = i + 1;
        if (acks == 1) first_d = rd_a;
      end
    end
    mem_rd_req = 1'b0;
    check("drop_ack_count_a", acks, 2);
    check("drop_last_ack_a", last_ack, 10);
    check("drop_first_data_a", first_d, 32'd2);
    @(negedge clk);

    // Unaligned addresses.
    txn(1'b1, 1'b0, 32'h43, '0, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("unal43_a", da, 32'hDEADBEEF);
    check("unal43_b", db, 32'h0);
    check("unal43_ack_b", nb, 1);
    txn(1'b1, 1'b0, 32'h07, '0, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("unal07_a", da, 32'd2);
    check("unal07_b", db, 32'd2);

    // Core write and side-band write land on the same word at the same edge.
    txn(1'b0, 1'b1, 32'h10, 32'h22, 6, 4, 32'h10, 32'h11, fa, fb, na, nb, ba, bb, da, db);
    txn(1'b1, 1'b0, 32'h10, '0, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("coll_a", da, 32'h22);
    check("coll_late_oob_b", db, 32'h11);
    txn(1'b0, 1'b1, 32'h14, 32'h33, 6, 0, 32'h14, 32'h11, fa, fb, na, nb, ba, bb, da, db);
    txn(1'b1, 1'b0, 32'h14, '0, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("coll_same_a", da, 32'h33);
    check("coll_same_b", db, 32'h33);

    // Both request lines high acts as a write; write ack keeps previous read data.
    txn(1'b1, 1'b1, 32'h18, 32'h55, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("both_hold_rd_a", da, 32'h33);
    check("both_hold_rd_b", db, 32'h33);
    txn(1'b1, 1'b0, 32'h18, '0, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("both_wr_a", da, 32'h55);
    check("both_wr_b", db, 32'h55);

    // Reset in the middle of a latency-5 write abandons it.
    oob(32'h20, 32'h77);
    acks = 0;
    mem_wr_req = 1'b1; mem_addr = 32'h20; mem_wr_data = 32'hAAAA;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      mem_wr_req = 1'b0;
      if (ack_a) acks++;
      if (i == 3) check("rst_mid_rd_a", rd_a, 32'h0);
      if (i == 3) check("rst_mid_busy_a", 32'(busy_a), 0);
      if (i == 2) #2 rst = 1'b0;
      if (i == 4) #2 rst = 1'b1;
    end
    check("rst_mid_ack_a", acks, 0);
    txn(1'b1, 1'b0, 32'h20, '0, 6, -1, '0, '0, fa, fb, na, nb, ba, bb, da, db);
    check("rst_mid_store_a", da, 32'h77);
    check("rst_mid_store_b", db, 32'hAAAA);

    // Random traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      mem_rd_req  = ($urandom_range(0, 2) == 0);
      mem_wr_req  = ($urandom_range(0, 3) == 0);
      mem_addr    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
      mem_wr_data = $urandom;
      oob_wr_en   = ($urandom_range(0, 5) == 0);
      oob_wr_addr = 32'($urandom_range(0, 127));
      oob_wr_data = $urandom;
      @(negedge clk);
    end
    mem_rd_req = 1'b0; mem_wr_req = 1'b0; oob_wr_en = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/global_mem_ctrl.md
# global_mem_ctrl

Single-outstanding-request memory controller sitting directly downstream of the processor's memory port. It holds a word-addressed backing store and answers each processor read or write after a fixed, parameterised latency. It raises `busy` while a request is in flight and pulses `ack` on completion. A side-band port lets the testbench load a program into memory before or between runs.

## Interface
Parameters:
- `MEM_SIZE_WORDS`, default 4096: depth of the backing store in 32-bit words.
- `LATENCY`, default 5: cycles from request sample to `ack`; legal range 1..255.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `mem_addr`, in, 32: byte address from the processor.
- `mem_rd_req`, in, 1: read request, one-cycle pulse.
- `mem_wr_req`, in, 1: write request, one-cycle pulse.
- `mem_wr_data`, in, 32: write data, sampled with `mem_wr_req`.
- `mem_rd_data`, out, 32: read data, valid in the `mem_ack` cycle.
- `mem_ack`, out, 1: completion pulse, exactly one cycle long.
- `mem_busy`, out, 1: high while a request is in flight.
- `oob_wr_en`, in, 1: side-band write strobe.
- `oob_wr_addr`, in, 32: side-band byte address.
- `oob_wr_data`, in, 32: side-band write data.

## Operation
- States: `IDLE` and `WAIT`. All outputs are registered.
- Request acceptance:
  - A request is sampled only in `IDLE`. This includes the cycle in which `mem_ack` is high, so back-to-back requests are supported.
  - Requests while in `WAIT` are dropped silently; they are not queued.
- `IDLE` with a request:
  - Latch the word index, data and type.
  - `LATENCY==1`: complete at the next edge and stay in `IDLE`.
  - Otherwise load `cnt = LATENCY-2` and go to `WAIT`.
- `WAIT`: decrement `cnt` each cycle. When `cnt==0`, complete and return to `IDLE`.
- Completion, performed at one edge:
  - Read: `mem_rd_data <= store[idx]`.
  - Write: `store[idx] <= data`; `mem_rd_data` holds its previous value.
  - In both cases `mem_ack <= 1` for one cycle.
- Addressing:
  - `idx = mem_addr[31:2]`; `mem_addr[1:0]` is ignored.
  - If `idx >= MEM_SIZE_WORDS`: a read returns 0 and a write is discarded. `ack` is still given.
- Both `mem_rd_req` and `mem_wr_req` high in the same cycle: treated as a write.
- Side-band write:
  - `oob_wr_en` writes `store[oob_wr_addr[31:2]]` at the edge, in any state. Out-of-range writes are discarded.
  - If it hits the same word as a completing core write in the same cycle, the core write wins.
- Read-after-write: a read that completes after a write completion observes the new data.
- Reset (`rst` low, asynchronous):
  - `mem_ack=0`, `mem_busy=0`, `mem_rd_data=0`, state `IDLE`, `cnt=0`.
  - Store contents are not cleared.
  - A transaction in flight is abandoned: no `ack`, and its write is not performed.

## Timing
- A request sampled at edge T gives `mem_ack` high in cycle T+`LATENCY`, meaning after edge T+`LATENCY`-1 and before edge T+`LATENCY`.
- `mem_busy` is high from the cycle after the request edge up to, but not including, the `ack` cycle. It is never high when `LATENCY==1`.
- `mem_busy` and `mem_ack` are never high together.
- Minimum request-to-request spacing is `LATENCY` cycles. A new request is legal in the `ack` cycle.
- Release of `rst` is treated asynchronously on assert. The first request is accepted at the first rising edge with `rst` high.

## Structure
- Shared package `mem_pkg`: `e_mem_state` enum (`IDLE`, `WAIT`) and the default latency constant.
- One sub-module, `global_mem_array`: storage with one read port, a core write port and a side-band write port, with the core port taking priority. Synchronous write, combinational read, no reset.
- The top level owns the FSM, counter, address decode and output registers.

## Test plan
- Reset, `LATENCY=5`: hold `rst` low, pulse `mem_rd_req` -> `mem_ack`, `mem_busy` and `mem_rd_data` all stay 0. Assert `rst` mid-`WAIT` -> no `ack` and no store update.
- Write then read: write `0xDEADBEEF` to address 0x40, then read address 0x40 -> `ack` in cycle T+5 both times, `busy` high for 4 cycles each time, read data `0xDEADBEEF`.
- Back-to-back at `LATENCY=1`: reads at 0x0, 0x4, 0x8 on consecutive cycles, preloaded via side-band with 1, 2, 3 -> three consecutive `ack` cycles with data 1, 2, 3, and `busy` never high.
- Dropped request: issue a read while `busy`, then a read in the `ack` cycle -> the first yields no extra `ack`; the second is accepted and acked 5 cycles later.
- Out of range, `MEM_SIZE_WORDS=16`: write then read address 0x40 -> both acked, read data 0. Unaligned read of 0x43 returns `store[16]`'s behaviour (0). Read of 0x07 returns the word at 0x04.
- Collision: side-band write of 0x11 and core write of 0x22 completing on the same word in the same cycle -> a subsequent read returns 0x22. Both request lines high -> handled as a write.
